// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate response checker and the gate reference model.
package gate_chk_pkg;

  // Expected-function selectors
  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  // Checker run states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the example gates: exp = f_op(a, b), bitwise.
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp
);

  // Select the bitwise function; an unknown selector yields all zeros
  always_comb begin
    exp = {WIDTH{1'b0}};
    case (op)
      OP_AND:  exp = a & b;
      OP_OR:   exp = a | b;
      OP_XOR:  exp = a ^ b;
      OP_NAND: exp = ~(a & b);
      default: exp = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Hardware self-checking monitor for a gate DUT: compares each valid sample
// against the reference model and counts samples and failures over a run.
// Optional first-failure capture is enabled by defining GATE_CHECKER_FIRST_FAIL_EN.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_W       = 8,
  parameter int OP          = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_out
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       op_s;
  logic [WIDTH-1:0] exp_s;
  logic             fail_s;
  logic             accept_s;
  logic [CNT_W-1:0] sample_next_s;
  logic [CNT_W-1:0] err_next_s;
  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  state_t           state_r;

  assign op_s = 2'(OP);

  gate_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .op  (op_s),
    .a   (a),
    .b   (b),
    .exp (exp_s)
  );

  // Reset synchronizer: assertion passes straight through, release waits two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Sample qualification and next-count arithmetic; err count saturates at all-ones
  always_comb begin
    fail_s        = (dut_out != exp_s);
    accept_s      = (state_r == ST_RUN) && in_valid && !start;
    sample_next_s = sample_cnt + CNT_ONE;
    if (fail_s && (err_cnt != CNT_MAX)) begin
      err_next_s = err_cnt + CNT_ONE;
    end else begin
      err_next_s = err_cnt;
    end
  end

  // Run-control FSM with registered status outputs and counters
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r    <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      sample_cnt <= {CNT_W{1'b0}};
      err_cnt    <= {CNT_W{1'b0}};
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        // A start from any state opens a fresh run; a same-cycle sample is dropped
        state_r    <= ST_RUN;
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
        sample_cnt <= {CNT_W{1'b0}};
        err_cnt    <= {CNT_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_RUN: begin
            if (in_valid) begin
              sample_cnt <= sample_next_s;
              err_cnt    <= err_next_s;
              mismatch   <= fail_s;
              if (sample_next_s == LAST_CNT) begin
                state_r <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= (err_next_s == {CNT_W{1'b0}});
              end else begin
                state_r <= ST_RUN;
              end
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_DONE: state_r <= ST_DONE;
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  // Latch the first failing sample of a run; cleared by start
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      first_fail_valid <= 1'b0;
      first_a          <= {WIDTH{1'b0}};
      first_b          <= {WIDTH{1'b0}};
      first_out        <= {WIDTH{1'b0}};
    end else if (start) begin
      first_fail_valid <= 1'b0;
      first_a          <= {WIDTH{1'b0}};
      first_b          <= {WIDTH{1'b0}};
      first_out        <= {WIDTH{1'b0}};
    end else if (accept_s && fail_s && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_a          <= a;
      first_b          <= b;
      first_out        <= dut_out;
    end else begin
      first_fail_valid <= first_fail_valid;
    end
  end
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed, table-driven bench for gate_response_checker.
module tb_gate_response_checker;

  typedef struct {
    logic st;
    logic iv;
    logic a;
    logic b;
    logic o;
    logic busy;
    logic done;
    logic pass;
    logic mm;
    int   sc;
    int   ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start = 1'b0, in_valid = 1'b0;
  logic [0:0] a = 1'b0, b = 1'b0, dut_out = 1'b0;
  logic busy, done, pass, mismatch;
  logic [7:0] sample_cnt, err_cnt;

  logic start2 = 1'b0, in_valid2 = 1'b0;
  logic [0:0] a2 = 1'b0, b2 = 1'b0, dut_out2 = 1'b0;
  logic busy2, done2, pass2, mismatch2;
  logic [1:0] sample_cnt2, err_cnt2;

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic       ffv, ffv2;
  logic [0:0] fa, fb, fo, fa2, fb2, fo2;
`endif

  int checks = 0;
  int errors = 0;
  vec_t tbl[19];

  always #5 clk = ~clk;

  gate_response_checker #(.WIDTH(1), .NUM_SAMPLES(4), .CNT_W(8), .OP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt)
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv), .first_a(fa), .first_b(fb), .first_out(fo)
`endif
  );

  gate_response_checker #(.WIDTH(1), .NUM_SAMPLES(3), .CNT_W(2), .OP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
    .a(a2), .b(b2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
    .sample_cnt(sample_cnt2), .err_cnt(err_cnt2)
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv2), .first_a(fa2), .first_b(fb2), .first_out(fo2)
`endif
  );

  function automatic vec_t v(input logic st, input logic iv, input logic va,
                             input logic vb, input logic vo, input logic bz,
                             input logic dn, input logic ps, input logic mm,
                             input int sc, input int ec);
    vec_t t;
    t.st = st; t.iv = iv; t.a = va; t.b = vb; t.o = vo;
    t.busy = bz; t.done = dn; t.pass = ps; t.mm = mm; t.sc = sc; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle on the main instance; outputs sampled 1 time unit after the edge
  task automatic drive(input logic st, input logic iv, input logic va,
                       input logic vb, input logic vo);
    start = st; in_valid = iv; a = va; b = vb; dut_out = vo;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drive2(input logic st, input logic iv, input logic va,
                        input logic vb, input logic vo);
    start2 = st; in_valid2 = iv; a2 = va; b2 = vb; dut_out2 = vo;
    @(posedge clk);
    #1;
    start2 = 1'b0; in_valid2 = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic bz, input logic dn,
                         input logic ps, input logic mm, input int sc, input int ec);
    chk({tag, " busy"}, int'(busy), int'(bz));
    chk({tag, " done"}, int'(done), int'(dn));
    chk({tag, " pass"}, int'(pass), int'(ps));
    chk({tag, " mismatch"}, int'(mismatch), int'(mm));
    chk({tag, " sample_cnt"}, int'(sample_cnt), sc);
    chk({tag, " err_cnt"}, int'(err_cnt), ec);
  endtask

  task automatic chk2(input string tag, input logic bz, input logic dn,
                      input logic ps, input logic mm, input int sc, input int ec);
    chk({tag, " busy"}, int'(busy2), int'(bz));
    chk({tag, " done"}, int'(done2), int'(dn));
    chk({tag, " pass"}, int'(pass2), int'(ps));
    chk({tag, " mismatch"}, int'(mismatch2), int'(mm));
    chk({tag, " sample_cnt"}, int'(sample_cnt2), sc);
    chk({tag, " err_cnt"}, int'(err_cnt2), ec);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].st, tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].o);
      chk_all($sformatf("row%0d", i), tbl[i].busy, tbl[i].done, tbl[i].pass,
              tbl[i].mm, tbl[i].sc, tbl[i].ec);
    end
  endtask

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  task automatic chk_first(input string tag, input logic vv, input logic va,
                           input logic vb, input logic vo);
    chk({tag, " first_fail_valid"}, int'(ffv), int'(vv));
    chk({tag, " first_a"}, int'(fa), int'(va));
    chk({tag, " first_b"}, int'(fb), int'(vb));
    chk({tag, " first_out"}, int'(fo), int'(vo));
  endtask
`endif

  initial begin
    //                st    iv    a     b     o     busy  done  pass  mm    sc ec
    // Correct AND run, then a wrong sample offered in DONE
    tbl[0]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[1]  = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[2]  = v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    tbl[3]  = v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    tbl[4]  = v(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
    tbl[5]  = v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
    // Run with a failing third sample 10 -> 1
    tbl[6]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[7]  = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[8]  = v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    tbl[9]  = v(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1);
    tbl[10] = v(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1);
    // Restart mid-run with a same-cycle failing sample that must be dropped
    tbl[11] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[12] = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[13] = v(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1);
    tbl[14] = v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[15] = v(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[16] = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    tbl[17] = v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    tbl[18] = v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0);

    // Reset, then let the release propagate through the synchronizer
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk2("reset2", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Samples in IDLE, including a wrong one, are ignored
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("idle_iv", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    run_rows(0, 10);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    chk_first("capture", 1'b1, 1'b1, 1'b0, 1'b1);
`endif
    run_rows(11, 11);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    chk_first("cleared", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    run_rows(12, 13);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    chk_first("capture2", 1'b1, 1'b0, 1'b1, 1'b1);
`endif
    run_rows(14, 14);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    chk_first("restart_clr", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    run_rows(15, 18);

    // Asynchronous reset mid-run after three samples
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_all("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1, 3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_all("post_rst_iv", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Narrow-counter XOR checker fed an always-wrong response
    drive2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk2("sat_start", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive2(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk2("sat_s1", 1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
    drive2(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk2("sat_s2", 1'b1, 1'b0, 1'b0, 1'b1, 2, 2);
    drive2(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk2("sat_s3", 1'b0, 1'b1, 1'b0, 1'b1, 3, 3);
    drive2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk2("sat_hold", 1'b0, 1'b1, 1'b0, 1'b0, 3, 3);
    drive2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk2("sat_restart", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable self-checking monitor for the logic-gate examples. It watches the stimulus (a, b) applied to a gate DUT and the DUT's response (dut_out). Each valid sample is compared against the expected bitwise function, and mismatches and samples are counted over a run of fixed length. It sits beside the DUT, so the checking a simulation-only bench would do runs in hardware.

Parameters:
WIDTH, 1, bit width of a, b and dut_out
NUM_SAMPLES, 8, samples per run; legal range 1 to 2**CNT_W-1
CNT_W, 8, width of the sample and error counters
OP, 0, expected function: 0=AND, 1=OR, 2=XOR, 3=NAND

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a new run
in_valid  input  1  a, b and dut_out are a valid sample this cycle
a  input  WIDTH  stimulus operand A
b  input  WIDTH  stimulus operand B
dut_out  input  WIDTH  DUT response to a/b
busy  output  1  high while in RUN
done  output  1  high in DONE until the next start
pass  output  1  valid when done: err_cnt==0
mismatch  output  1  one-cycle pulse, one cycle after a failing sample
sample_cnt  output  CNT_W  samples accepted this run
err_cnt  output  CNT_W  failing samples this run, saturating

Behaviour:
- Reset (async assert, sync release). State=IDLE. busy=0, done=0, pass=0, mismatch=0, sample_cnt=0, err_cnt=0.
- Expected value: exp = f_OP(a,b), bitwise over WIDTH. A sample fails if dut_out != exp in any bit.
- IDLE: in_valid is ignored. start -> RUN next cycle; the counters clear on that same edge.
- RUN: busy=1. On each cycle with in_valid=1:
  - sample_cnt increments.
  - If the sample fails, err_cnt increments (saturates at all-ones) and mismatch pulses high the next cycle.
- RUN -> DONE: on the edge where the accepted sample brings sample_cnt to NUM_SAMPLES.
  - That final sample is checked and counted like any other.
  - Further in_valid is ignored.
- DONE: done=1, busy=0. pass = (err_cnt==0), registered on entry. Counters hold their values.
- start in DONE: clears the counters, done and pass. -> RUN next cycle.
- start in RUN: restarts the run. Counters clear. Any in_valid in that same cycle is discarded, and that sample produces no mismatch.
- start with in_valid in IDLE or DONE: the sample is discarded.
- in_valid with no start: never counted outside RUN.
- Latency: mismatch, sample_cnt and err_cnt all update 1 cycle after the sample edge.
- rst_n low at any time returns all state to reset values immediately, including mid-run.

Optional Feature:
Macro: GATE_CHECKER_FIRST_FAIL_EN
- Defined:
  - Adds outputs first_fail_valid (1), first_a, first_b, first_out (WIDTH each).
  - These capture the first failing sample of a run, one cycle after it.
  - They hold until the next start or reset, which clears all four to 0.
  - Later failures do not overwrite the capture.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package gate_chk_pkg:
  - OP encodings OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3.
  - State encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One natural sub-module: gate_ref_model. It is combinational, takes (OP, a, b) and produces exp. It is reused by future gate examples.

Test Plan:
1. AND, WIDTH=1, NUM_SAMPLES=4, correct DUT. Drive ab=00,01,10,11 -> dut_out=0,0,0,1; sample_cnt=4, err_cnt=0, done=1, pass=1, mismatch never high.
2. AND, a 3rd sample ab=10 with dut_out=1 -> mismatch high on the cycle after it; final err_cnt=1, pass=0; with the macro, first_a=1, first_b=0, first_out=1.
3. start in RUN after 2 samples, in_valid=1 in that same cycle -> counters return to 0 and the sample is discarded; after 4 more correct samples, sample_cnt=4.
4. in_valid pulses in IDLE and DONE -> sample_cnt and err_cnt unchanged, no mismatch.
5. rst_n driven low mid-run after 3 samples -> all outputs return to 0 immediately; with no start, a following in_valid is not counted.
6. CNT_W=2, NUM_SAMPLES=3, always-wrong DUT -> err_cnt reaches 3 and stays there, pass=0; a new start clears err_cnt to 0.
